// File: rtl/muldiv_seq.sv
// Sequencer for one MUL/DIV datapath operation.
// Walks IDLE -> LDY -> EXE -> WLO -> WHI -> FIN. A DIV with a zero divisor
// seen in EXE diverts to ABT. All outputs decode the registered state and
// operand latches, gated by stall and bus_zero.
module muldiv_seq (
  input  logic        Clock,
  input  logic        clear,
  input  logic        start,
  input  logic        is_div,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  input  logic        stall,
  input  logic        bus_zero,
  output logic [15:0] Rout,
  output logic        Yin,
  output logic        ZHighin,
  output logic        Zlowin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        LOin,
  output logic        HIin,
  output logic [4:0]  op,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDY  = 3'd1,
    S_EXE  = 3'd2,
    S_WLO  = 3'd3,
    S_WHI  = 3'd4,
    S_FIN  = 3'd5,
    S_ABT  = 3'd6
  } state_t;

  localparam logic [4:0] OP_MUL = 5'b01010;
  localparam logic [4:0] OP_DIV = 5'b01011;

  state_t     r_state;
  logic       r_div;
  logic [3:0] r_ra;
  logic [3:0] r_rb;
  logic       w_div_by_zero;

  assign w_div_by_zero = r_div & bus_zero;

  // State register and operand latches; start is only honoured in IDLE.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_IDLE;
      r_div   <= 1'b0;
      r_ra    <= '0;
      r_rb    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_div   <= is_div;
            r_ra    <= ra;
            r_rb    <= rb;
            r_state <= S_LDY;
          end
        end
        S_LDY: if (!stall) r_state <= S_EXE;
        S_EXE: if (!stall) r_state <= w_div_by_zero ? S_ABT : S_WLO;
        S_WLO: if (!stall) r_state <= S_WHI;
        S_WHI: if (!stall) r_state <= S_FIN;
        S_FIN: if (!stall) r_state <= S_IDLE;
        S_ABT: if (!stall) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output decode; a stalled cycle keeps only busy so nothing fires twice.
  always_comb begin
    Rout     = '0;
    Yin      = 1'b0;
    ZHighin  = 1'b0;
    Zlowin   = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    op       = '0;
    done     = 1'b0;
    err      = 1'b0;
    busy     = (r_state != S_IDLE);
    if (!stall) begin
      case (r_state)
        S_LDY: begin
          Rout[r_ra] = 1'b1;
          Yin        = 1'b1;
        end
        S_EXE: begin
          Rout[r_rb] = 1'b1;
          op         = r_div ? OP_DIV : OP_MUL;
          ZHighin    = ~w_div_by_zero;
          Zlowin     = ~w_div_by_zero;
        end
        S_WLO: begin
          Zlowout = 1'b1;
          LOin    = 1'b1;
        end
        S_WHI: begin
          Zhighout = 1'b1;
          HIin     = 1'b1;
        end
        S_FIN:   done = 1'b1;
        S_ABT:   err  = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a sequence-step model.
module tb_muldiv_seq;

  logic        Clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        is_div = 1'b0;
  logic [3:0]  ra = '0;
  logic [3:0]  rb = '0;
  logic        stall = 1'b0;
  logic        bus_zero = 1'b0;
  logic [15:0] Rout;
  logic        Yin, ZHighin, Zlowin, Zlowout, Zhighout, LOin, HIin;
  logic [4:0]  op;
  logic        busy, done, err;

  int checks = 0;
  int failures = 0;

  muldiv_seq u_dut (
    .Clock(Clock), .clear(clear), .start(start), .is_div(is_div),
    .ra(ra), .rb(rb), .stall(stall), .bus_zero(bus_zero),
    .Rout(Rout), .Yin(Yin), .ZHighin(ZHighin), .Zlowin(Zlowin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .LOin(LOin), .HIin(HIin),
    .op(op), .busy(busy), .done(done), .err(err)
  );

  always #5 Clock = ~Clock;

  // Output vector: {Rout, Yin, ZHighin, Zlowin, Zlowout, Zhighout, LOin, HIin, op, busy, done, err}
  logic [30:0] w_dut;
  assign w_dut = {Rout, Yin, ZHighin, Zlowin, Zlowout, Zhighout, LOin, HIin, op, busy, done, err};

  // Model: position within the fixed step list of one operation
  // (0 = not running, 1 = load Y, 2 = execute, 3 = write LO, 4 = write HI,
  //  5 = finished, 6 = aborted).
  int         m_step = 0;
  logic       m_div = 1'b0;
  logic [3:0] m_ra = '0;
  logic [3:0] m_rb = '0;

  function automatic logic [30:0] model_out(int step, logic dv, logic [3:0] a, logic [3:0] b,
                                            logic stl, logic bz, logic clr);
    logic [15:0] rsel;
    logic [6:0]  str;
    logic [4:0]  opc;
    logic [2:0]  st;
    rsel = '0; str = '0; opc = '0; st = '0;
    if (clr) begin
      st[2] = (step != 0);
      if (!stl) begin
        if (step == 1) begin rsel = 16'(1) << a; str = 7'b1000000; end
        if (step == 2) begin
          rsel = 16'(1) << b;
          opc = dv ? 5'd11 : 5'd10;
          str = (dv && bz) ? 7'b0000000 : 7'b0110000;
        end
        if (step == 3) str = 7'b0001010;
        if (step == 4) str = 7'b0000101;
        if (step == 5) st[1] = 1'b1;
        if (step == 6) st[0] = 1'b1;
      end
    end
    return {rsel, str, opc, st};
  endfunction

  // Every-cycle compare at the falling edge, then advance the model using
  // the inputs that the next rising edge will sample.
  always @(negedge Clock) begin
    logic [30:0] e;
    e = model_out(m_step, m_div, m_ra, m_rb, stall, bus_zero, clear);
    checks++;
    if (w_dut !== e) begin
      failures++;
      $display("FAIL model_cmp t=%0t step=%0d got=%h want=%h", $time, m_step, w_dut, e);
    end
    if (!clear) begin
      m_step = 0; m_div = 1'b0; m_ra = '0; m_rb = '0;
    end else if (m_step == 0) begin
      if (start) begin m_step = 1; m_div = is_div; m_ra = ra; m_rb = rb; end
    end else if (!stall) begin
      if (m_step == 2 && m_div && bus_zero) m_step = 6;
      else if (m_step >= 5)                  m_step = 0;
      else                                   m_step = m_step + 1;
    end
  end

  task automatic nxt();
    @(posedge Clock);
    #1;
  endtask

  task automatic expv(input string name, input logic [30:0] want);
    @(negedge Clock);
    checks++;
    if (w_dut !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, w_dut, want);
    end
  endtask

  localparam logic [30:0] V_IDLE = 31'd0;
  localparam logic [30:0] V_WLO  = {16'h0000, 7'b0001010, 5'd0, 3'b100};
  localparam logic [30:0] V_WHI  = {16'h0000, 7'b0000101, 5'd0, 3'b100};
  localparam logic [30:0] V_FIN  = {16'h0000, 7'b0000000, 5'd0, 3'b110};
  localparam logic [30:0] V_ABT  = {16'h0000, 7'b0000000, 5'd0, 3'b101};
  localparam logic [30:0] V_STL  = {16'h0000, 7'b0000000, 5'd0, 3'b100};

  initial begin
    // Reset state
    expv("reset", V_IDLE);
    nxt();
    clear = 1'b1;

    // MUL ra=2 rb=3, no stall
    nxt();
    start = 1'b1; is_div = 1'b0; ra = 4'd2; rb = 4'd3;
    nxt(); start = 1'b0;
    expv("mul_ldy", {16'h0004, 7'b1000000, 5'd0, 3'b100});
    nxt(); expv("mul_exe", {16'h0008, 7'b0110000, 5'b01010, 3'b100});
    nxt(); expv("mul_wlo", V_WLO);
    nxt(); expv("mul_whi", V_WHI);
    nxt(); expv("mul_fin", V_FIN);
    nxt(); expv("mul_idle", V_IDLE);

    // DIV ra=5 rb=6 with zero divisor on the bus in EXE
    start = 1'b1; is_div = 1'b1; ra = 4'd5; rb = 4'd6;
    nxt(); start = 1'b0;
    expv("div_ldy", {16'h0020, 7'b1000000, 5'd0, 3'b100});
    nxt(); bus_zero = 1'b1;
    expv("div_exe_z", {16'h0040, 7'b0000000, 5'b01011, 3'b100});
    nxt(); bus_zero = 1'b0;
    expv("div_abt", V_ABT);
    nxt(); expv("div_idle", V_IDLE);

    // MUL with 2 stalled cycles in WLO: done lands in cycle 7
    start = 1'b1; is_div = 1'b0; ra = 4'd0; rb = 4'd15;
    nxt(); start = 1'b0;
    expv("stl_c1", {16'h0001, 7'b1000000, 5'd0, 3'b100});
    nxt(); expv("stl_c2", {16'h8000, 7'b0110000, 5'b01010, 3'b100});
    nxt(); stall = 1'b1; expv("stl_c3", V_STL);
    nxt(); expv("stl_c4", V_STL);
    nxt(); stall = 1'b0; expv("stl_c5", V_WLO);
    nxt(); expv("stl_c6", V_WHI);
    nxt(); expv("stl_c7", V_FIN);
    nxt(); expv("stl_idle", V_IDLE);

    // start with ra=7 during EXE must be ignored
    start = 1'b1; is_div = 1'b0; ra = 4'd4; rb = 4'd9;
    nxt(); start = 1'b0;
    expv("ign_ldy", {16'h0010, 7'b1000000, 5'd0, 3'b100});
    nxt(); start = 1'b1; ra = 4'd7; is_div = 1'b1;
    expv("ign_exe", {16'h0200, 7'b0110000, 5'b01010, 3'b100});
    nxt(); start = 1'b0; expv("ign_wlo", V_WLO);
    nxt(); expv("ign_whi", V_WHI);
    nxt(); expv("ign_fin", V_FIN);
    nxt(); expv("ign_idle", V_IDLE);

    // Asynchronous clear mid-EXE, then a fresh MUL ra=1 rb=1
    start = 1'b1; is_div = 1'b0; ra = 4'd3; rb = 4'd4;
    nxt(); start = 1'b0;
    nxt();
    #2 clear = 1'b0;
    #1;
    checks++;
    if (w_dut !== V_IDLE) begin
      failures++;
      $display("FAIL clr_async got=%h want=%h", w_dut, V_IDLE);
    end
    nxt(); clear = 1'b1; start = 1'b1; ra = 4'd1; rb = 4'd1;
    nxt(); start = 1'b0;
    expv("clr_ldy", {16'h0002, 7'b1000000, 5'd0, 3'b100});
    nxt(); expv("clr_exe", {16'h0002, 7'b0110000, 5'b01010, 3'b100});
    nxt(); expv("clr_wlo", V_WLO);
    nxt(); expv("clr_whi", V_WHI);
    nxt(); expv("clr_fin", V_FIN);

    // Randomized traffic, checked every cycle by the model process
    for (int i = 0; i < 600; i++) begin
      nxt();
      start    = ($urandom_range(2) == 0);
      is_div   = 1'($urandom);
      ra       = 4'($urandom);
      rb       = 4'($urandom);
      stall    = ($urandom_range(3) == 0);
      bus_zero = 1'($urandom);
      clear    = ($urandom_range(59) != 0);
    end
    nxt();
    clear = 1'b1; start = 1'b0; stall = 1'b0;
    repeat (10) nxt();
    @(negedge Clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL use no parameters; all widths are fixed as listed below.
REQ-002 Clock  input  1  Rising-edge clock; all state changes on its rising edge.
REQ-003 clear  input  1  Reset, asynchronous, active-low.
REQ-004 start  input  1  Request to run one MUL/DIV sequence; sampled only in IDLE.
REQ-005 is_div  input  1  0 = MUL, 1 = DIV; captured with start.
REQ-006 ra  input  4  First source register index; captured with start.
REQ-007 rb  input  4  Second source register index; captured with start.
REQ-008 stall  input  1  Datapath wait; freezes the sequence.
REQ-009 bus_zero  input  1  High when the datapath bus value equals 0.
REQ-010 Rout  output  16  One-hot register-to-bus enables R0out..R15out.
REQ-011 Yin, ZHighin, Zlowin, Zlowout, Zhighout, LOin, HIin  output  1 each  Datapath strobes.
REQ-012 op  output  5  ALU opcode.
REQ-013 busy, done, err  output  1 each  Status.

Function
REQ-014 States SHALL be IDLE, LDY, EXE, WLO, WHI, FIN and ABT, binary-encoded.
REQ-015 In IDLE with start=1, the block SHALL latch is_div/ra/rb and go to LDY; start in any other state SHALL be ignored.
REQ-016 Transitions SHALL follow LDY->EXE->WLO->WHI->FIN->IDLE, one state per cycle when stall=0.
REQ-017 When stall=1 in any non-IDLE state, the block SHALL hold its state and drive all strobes, Rout and op to 0 that cycle.
REQ-018 LDY SHALL drive Rout bit [ra_latched] and Yin for one cycle.
REQ-019 EXE SHALL drive Rout bit [rb_latched] and op = 5'b01010 (MUL) or 5'b01011 (DIV).
REQ-020 In EXE, ZHighin and Zlowin SHALL be driven high unless the latched op is DIV and bus_zero=1.
REQ-021 In EXE with the latched op DIV and bus_zero=1 (and stall=0), the block SHALL go to ABT instead of WLO.
REQ-022 op SHALL be 0 in every state except EXE.
REQ-023 WLO SHALL drive Zlowout and LOin.
REQ-024 WHI SHALL drive Zhighout and HIin.
REQ-025 FIN SHALL drive done=1 for exactly one cycle; ABT SHALL drive err=1 for exactly one cycle; both SHALL then return to IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 Rout SHALL have at most one bit set; ra equal to rb is legal.
REQ-028 Latency from start sampled in IDLE to done SHALL be 5 cycles with no stall, plus one cycle per stalled cycle.
REQ-029 All outputs SHALL be combinational decodes of the registered state and latches only, with gating by stall and bus_zero.

Reset
REQ-030 clear=0 SHALL immediately force IDLE, clear the latches to 0, and drive every output to 0, including mid-sequence.
REQ-031 After clear rises, the first start SHALL be sampled no earlier than the next rising edge.

Verification
REQ-032 MUL, ra=2, rb=3, no stall -> cycles 1-5 show Rout=0x0004+Yin; Rout=0x0008+op=01010+ZHighin/Zlowin; Zlowout+LOin; Zhighout+HIin; done.
REQ-033 DIV, ra=5, rb=6, bus_zero=1 in EXE -> ZHighin/Zlowin stay 0, err pulses in the next cycle, LOin/HIin never assert, busy=0 after.
REQ-034 MUL with stall=1 for 2 cycles during WLO -> strobes are 0 while stalled, WLO repeats, and done arrives at cycle 7.
REQ-035 start=1 with ra=7 during EXE of a running op -> ignored, and Rout bit 7 never asserts in that run.
REQ-036 clear=0 asserted mid-EXE -> all outputs go to 0 asynchronously; after release, a new MUL ra=1, rb=1 completes in 5 cycles with Rout=0x0002 in LDY and EXE.
